character_motion_ctrl: RTL and testbench

Frame-rate vertical motion controller for one player character. Converts a debounced jump button into a jump/gravity trajectory and drives the character's top-edge y position and enable to the character draw logic. Also holds the collision death state and blinks the character while dead. Updates happen once per video frame, on a one-cycle frame tick from the VGA timing block.

---
 rtl/motion_pkg.sv | 14 +
 rtl/rise_edge.sv | 19 +
 rtl/character_motion_ctrl.sv | 140 ++++++++++++++
 tb/tb_character_motion_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/motion_pkg.sv
// Shared types and widths for the character vertical-motion controller.
package motion_pkg;

  localparam int unsigned VEL_W = 5;
  localparam int unsigned Y_W   = 9;

  typedef enum logic [1:0] {
    ST_GROUND = 2'd0,
    ST_RISE   = 2'd1,
    ST_FALL   = 2'd2,
    ST_DEAD   = 2'd3
  } motion_state_t;

endpackage

// File: rtl/rise_edge.sv
// Rising-edge detector for a synchronous button level; one-cycle pulse per 0->1 change.
module rise_edge (
  input  logic clk,
  input  logic reset,
  input  logic i_level,
  output logic o_pulse
);

  logic r_prev;

  // Previous level clears on reset, so a level held through reset release yields one edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_prev <= 1'b0;
    else       r_prev <= i_level;
  end

  assign o_pulse = i_level & ~r_prev;

endmodule

// File: rtl/character_motion_ctrl.sv
// Per-frame jump/gravity controller for one character, with death state and blinking.
module character_motion_ctrl
  import motion_pkg::*;
#(
  parameter int unsigned GROUND_Y = 380,
  parameter int unsigned CEIL_Y   = 20,
  parameter int unsigned JUMP_V0  = 12,
  parameter int unsigned GRAVITY  = 1,
  parameter int unsigned VMAX     = 15
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           i_frame_tick,
  input  logic           i_jump,
  input  logic           i_pause,
  input  logic           i_hit,
  input  logic           i_restart,
  output logic [Y_W-1:0] o_ypos,
  output logic           o_en,
  output logic           o_airborne,
  output logic           o_dead
);

  motion_state_t      r_state, w_state_nx;
  logic [Y_W-1:0]     r_ypos, w_ypos_nx;
  logic [VEL_W-1:0]   r_vel, w_vel_nx;
  logic               r_pend, w_pend_nx;
  logic [2:0]         r_blink, w_blink_nx;

  logic               w_edge;
  logic               w_hit_now;
  logic               w_eff;
  logic signed [Y_W:0] w_diff;
  logic [Y_W:0]       w_sum;
  logic [VEL_W:0]     w_vinc;

  rise_edge u_jump_edge (
    .clk     (clk),
    .reset   (reset),
    .i_level (i_jump),
    .o_pulse (w_edge)
  );

  assign w_hit_now = i_hit & (r_state != ST_DEAD);
  assign w_eff     = i_frame_tick & ~i_pause & ~w_hit_now;
  // One extra bit so ypos-vel can go negative and ypos+vel cannot wrap.
  assign w_diff    = $signed({1'b0, r_ypos} - {{(Y_W-VEL_W+1){1'b0}}, r_vel});
  assign w_sum     = {1'b0, r_ypos} + {{(Y_W-VEL_W+1){1'b0}}, r_vel};
  assign w_vinc    = {1'b0, r_vel} + (VEL_W+1)'(GRAVITY);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_GROUND;
      r_ypos  <= Y_W'(GROUND_Y);
      r_vel   <= '0;
      r_pend  <= 1'b0;
      r_blink <= '0;
    end else begin
      r_state <= w_state_nx;
      r_ypos  <= w_ypos_nx;
      r_vel   <= w_vel_nx;
      r_pend  <= w_pend_nx;
      r_blink <= w_blink_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_ypos_nx  = r_ypos;
    w_vel_nx   = r_vel;
    w_blink_nx = r_blink;
    w_pend_nx  = r_pend;

    // An edge coinciding with an effective tick is consumed by the clear.
    if (w_eff)                  w_pend_nx = 1'b0;
    else if (w_edge & ~i_pause) w_pend_nx = 1'b1;

    unique case (r_state)
      ST_GROUND: begin
        if (w_hit_now) begin
          w_state_nx = ST_DEAD;
        end else if (w_eff && r_pend) begin
          w_state_nx = ST_RISE;
          w_vel_nx   = VEL_W'(JUMP_V0);
        end
      end
      ST_RISE: begin
        if (w_hit_now) begin
          w_state_nx = ST_DEAD;
        end else if (w_eff) begin
          if (w_diff < $signed((Y_W+1)'(CEIL_Y))) begin
            w_ypos_nx  = Y_W'(CEIL_Y);
            w_vel_nx   = '0;
            w_state_nx = ST_FALL;
          end else begin
            w_ypos_nx = w_diff[Y_W-1:0];
            if (r_vel <= VEL_W'(GRAVITY)) begin
              w_vel_nx   = '0;
              w_state_nx = ST_FALL;
            end else begin
              w_vel_nx = r_vel - VEL_W'(GRAVITY);
            end
          end
        end
      end
      ST_FALL: begin
        if (w_hit_now) begin
          w_state_nx = ST_DEAD;
        end else if (w_eff) begin
          if (w_sum >= (Y_W+1)'(GROUND_Y)) begin
            w_ypos_nx  = Y_W'(GROUND_Y);
            w_vel_nx   = '0;
            w_state_nx = ST_GROUND;
          end else begin
            w_ypos_nx = w_sum[Y_W-1:0];
            w_vel_nx  = (w_vinc > (VEL_W+1)'(VMAX)) ? VEL_W'(VMAX) : w_vinc[VEL_W-1:0];
          end
        end
      end
      ST_DEAD: begin
        if (i_restart) begin
          w_state_nx = ST_GROUND;
          w_ypos_nx  = Y_W'(GROUND_Y);
          w_vel_nx   = '0;
          w_blink_nx = '0;
          w_pend_nx  = 1'b0;
        end else if (i_frame_tick) begin
          w_blink_nx = r_blink + 3'd1;
        end
      end
      default: w_state_nx = ST_GROUND;
    endcase
  end

  assign o_ypos     = r_ypos;
  assign o_en       = (r_state != ST_DEAD) | ~r_blink[2];
  assign o_airborne = (r_state == ST_RISE) | (r_state == ST_FALL);
  assign o_dead     = (r_state == ST_DEAD);

endmodule

// File: tb/tb_character_motion_ctrl.sv
// Checks two parameterisations of character_motion_ctrl against a frame-level trajectory model.
module tb_character_motion_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       i_frame_tick = 1'b0, i_jump = 1'b0, i_pause = 1'b0, i_hit = 1'b0, i_restart = 1'b0;
  logic [8:0] ya, yb;
  logic       ena, enb, aira, airb, deada, deadb;

  int n_vec = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  character_motion_ctrl u_dut_a (
    .clk(clk), .reset(reset), .i_frame_tick(i_frame_tick), .i_jump(i_jump),
    .i_pause(i_pause), .i_hit(i_hit), .i_restart(i_restart),
    .o_ypos(ya), .o_en(ena), .o_airborne(aira), .o_dead(deada)
  );

  character_motion_ctrl #(.JUMP_V0(31), .CEIL_Y(360)) u_dut_b (
    .clk(clk), .reset(reset), .i_frame_tick(i_frame_tick), .i_jump(i_jump),
    .i_pause(i_pause), .i_hit(i_hit), .i_restart(i_restart),
    .o_ypos(yb), .o_en(enb), .o_airborne(airb), .o_dead(deadb)
  );

  // Character described by height, speed, direction flags and button memory.
  typedef struct {
    int y;
    int v;
    bit air;
    bit up;
    bit dead;
    bit pend;
    bit prev;
    int blink;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t mdl_reset();
    mdl_t m;
    m.y = 380; m.v = 0; m.air = 0; m.up = 0; m.dead = 0;
    m.pend = 0; m.prev = 0; m.blink = 0;
    return m;
  endfunction

  function automatic mdl_t mdl_step(mdl_t m, int v0, int ceil_y,
                                    bit tick, bit jump, bit pause, bit hit, bit restart);
    bit edge_seen = jump && !m.prev;
    bit hit_now   = hit && !m.dead;
    bit eff       = tick && !pause && !hit_now;
    int n;
    m.prev = jump;
    if (m.dead) begin
      if (restart) begin
        m.dead = 0; m.air = 0; m.up = 0; m.y = 380; m.v = 0; m.blink = 0; m.pend = 0;
        return m;
      end
      if (tick) m.blink = (m.blink + 1) % 8;
    end else if (hit_now) begin
      m.dead = 1;
    end else if (eff) begin
      if (!m.air) begin
        if (m.pend) begin m.air = 1; m.up = 1; m.v = v0; end
      end else if (m.up) begin
        n = m.y - m.v;
        if (n < ceil_y) begin
          m.y = ceil_y; m.v = 0; m.up = 0;
        end else begin
          m.y = n;
          if (m.v <= 1) begin m.v = 0; m.up = 0; end
          else m.v = m.v - 1;
        end
      end else begin
        if (m.y + m.v >= 380) begin m.y = 380; m.v = 0; m.air = 0; end
        else begin m.y = m.y + m.v; m.v = (m.v + 1 > 15) ? 15 : m.v + 1; end
      end
    end
    if (eff) m.pend = 0;
    else if (edge_seen && !pause) m.pend = 1;
    return m;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    if (reset) begin
      ma = mdl_reset(); mb = mdl_reset();
    end else begin
      ma = mdl_step(ma, 12, 20,  i_frame_tick, i_jump, i_pause, i_hit, i_restart);
      mb = mdl_step(mb, 31, 360, i_frame_tick, i_jump, i_pause, i_hit, i_restart);
    end
  end

  always @(negedge clk) begin
    if (reset) begin
      ma = mdl_reset(); mb = mdl_reset();
    end
    chk("A.ypos", 32'(ya), 32'(ma.y));
    chk("A.en",   32'(ena), 32'(!ma.dead || (ma.blink < 4)));
    chk("A.air",  32'(aira), 32'(ma.air && !ma.dead));
    chk("A.dead", 32'(deada), 32'(ma.dead));
    chk("B.ypos", 32'(yb), 32'(mb.y));
    chk("B.en",   32'(enb), 32'(!mb.dead || (mb.blink < 4)));
    chk("B.air",  32'(airb), 32'(mb.air && !mb.dead));
    chk("B.dead", 32'(deadb), 32'(mb.dead));
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick1();
    i_frame_tick = 1'b1; cyc();
    i_frame_tick = 1'b0; cyc();
  endtask

  task automatic press();
    i_jump = 1'b1; cyc();
    i_jump = 1'b0; cyc();
  endtask

  task automatic land_a();
    for (int k = 0; k < 60 && aira; k++) tick1();
    chk("land.air", 32'(aira), 32'd0);
    chk("land.ypos", 32'(ya), 32'd380);
  endtask

  int          rise_tab [12] = '{368, 357, 347, 338, 330, 323, 317, 312, 308, 305, 303, 302};
  logic [15:0] blink_pat = 16'b1111000011110000;
  logic [8:0]  y_frozen;
  int          launches;
  logic        air_prev;
  int unsigned r;

  initial begin
    repeat (3) cyc();
    reset = 1'b0;
    cyc();
    chk("rst.ypos", 32'(ya), 32'd380);
    for (int k = 0; k < 5; k++) begin
      tick1();
      chk("idle.ypos", 32'(ya), 32'd380);
      chk("idle.en", 32'(ena), 32'd1);
      chk("idle.air", 32'(aira), 32'd0);
    end

    press();
    tick1();
    chk("launch.ypos", 32'(ya), 32'd380);
    chk("launch.air", 32'(aira), 32'd1);
    for (int k = 0; k < 12; k++) begin
      tick1();
      chk("rise.ypos", 32'(ya), 32'(rise_tab[k]));
      if (k == 0) chk("B.clamp", 32'(yb), 32'd360);
    end
    chk("apex.air", 32'(aira), 32'd1);
    land_a();

    i_pause = 1'b1; press();
    i_pause = 1'b0; cyc();
    tick1();
    chk("paused_jump.air", 32'(aira), 32'd0);
    press();
    repeat (4) tick1();
    chk("pre_pause.ypos", 32'(ya), 32'd347);
    i_pause = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick1();
      chk("pause.ypos", 32'(ya), 32'd347);
    end
    i_pause = 1'b0;
    tick1();
    chk("resume.ypos", 32'(ya), 32'd338);
    land_a();
    repeat (30) tick1();

    press();
    repeat (16) tick1();
    y_frozen = ya;
    i_hit = 1'b1; i_frame_tick = 1'b1; cyc();
    i_hit = 1'b0; i_frame_tick = 1'b0; cyc();
    chk("hit.ypos", 32'(ya), 32'(y_frozen));
    chk("hit.dead", 32'(deada), 32'd1);
    for (int k = 0; k < 16; k++) begin
      i_hit = k[0];
      chk("blink.en", 32'(ena), 32'(blink_pat[15-k]));
      tick1();
    end
    i_hit = 1'b0;
    i_restart = 1'b1; i_frame_tick = 1'b1; cyc();
    i_restart = 1'b0; i_frame_tick = 1'b0;
    chk("restart.ypos", 32'(ya), 32'd380);
    chk("restart.en", 32'(ena), 32'd1);
    chk("restart.dead", 32'(deada), 32'd0);
    cyc();

    i_jump = 1'b1; cyc();
    launches = 0; air_prev = aira;
    for (int k = 0; k < 45; k++) begin
      tick1();
      if (aira && !air_prev) launches++;
      air_prev = aira;
    end
    chk("held.launches", 32'(launches), 32'd1);
    reset = 1'b1; cyc();
    reset = 1'b0; cyc();
    tick1();
    chk("held_reset.air", 32'(aira), 32'd1);
    i_jump = 1'b0;
    repeat (2) tick1();
    chk("midrise.ypos", 32'(ya), 32'd357);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    chk("async.ypos", 32'(ya), 32'd380);
    chk("async.air", 32'(aira), 32'd0);
    cyc();
    reset = 1'b0;
    cyc();

    for (int k = 0; k < 4000; k++) begin
      r = $urandom;
      i_frame_tick = (r[1:0] == 2'd0);
      i_pause      = (r[4:2] == 3'd0);
      i_hit        = (r[10:5] == 6'd0);
      i_restart    = (r[14:11] == 4'd0);
      if (!i_frame_tick && r[17:15] == 3'd0) i_jump = ~i_jump;
      cyc();
    end
    i_frame_tick = 1'b0; i_hit = 1'b0; i_restart = 1'b0; i_pause = 1'b0;
    cyc();
    cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
